data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_if.sv | 26 ++
 rtl/data_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the MEM stage and its responder.
// master: pipeline side (drives request fields, receives load data / handshake).
// slave : memory responder side (receives request fields, drives R_Data, Resp_Valid, Stall_MEM, Misaligned).
interface data_memory_responder_if;
  logic        R_Enable;
  logic        W_Enable;
  logic [1:0]  R_Width;
  logic [1:0]  W_Width;
  logic        R_Signed;
  logic [31:0] Address;
  logic [31:0] W_Data;
  logic [31:0] R_Data;
  logic        Resp_Valid;
  logic        Stall_MEM;
  logic        Misaligned;

  modport master (
    output R_Enable, W_Enable, R_Width, W_Width, R_Signed, Address, W_Data,
    input  R_Data, Resp_Valid, Stall_MEM, Misaligned
  );

  modport slave (
    input  R_Enable, W_Enable, R_Width, W_Width, R_Signed, Address, W_Data,
    output R_Data, Resp_Valid, Stall_MEM, Misaligned
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised big-endian data RAM answering MEM-stage loads/stores with byte/half/word lanes.
// Latency: request seen in IDLE at edge N -> Resp_Valid during cycle N+1+WAIT_CYCLES.
// Backpressure: Stall_MEM (combinational) holds the pipeline from request until the response cycle.
// Ports: Clock, Reset_n (sync, active-low), bus (slave side of data_memory_responder_if).
// Optional: define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses and pulse Misaligned;
// otherwise misaligned low address bits are simply masked and Misaligned stays 0.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  data_memory_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, next_state;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  logic [CW-1:0] cnt;
  logic          wr_q, rd_q, sgn_q;
  logic [1:0]    r_width_q, w_width_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   r_data_q;

  logic          req;
  logic          commit;
  logic          acc_wr, acc_rd, acc_sgn, acc_mis;
  logic [1:0]    acc_rw, acc_ww, acc_width;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, wr_word, ld_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          is_byte, is_half;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Address[31:AW+2];

  assign req = bus.R_Enable | bus.W_Enable;

  // With WAIT_CYCLES=0 the access commits on the same edge it is accepted,
  // so the effective request comes straight from the bus while in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      acc_wr    = bus.W_Enable;
      acc_rd    = bus.R_Enable & ~bus.W_Enable;
      acc_sgn   = bus.R_Signed;
      acc_rw    = bus.R_Width;
      acc_ww    = bus.W_Width;
      acc_addr  = bus.Address[AW+1:0];
      acc_wdata = bus.W_Data;
    end else begin
      acc_wr    = wr_q;
      acc_rd    = rd_q;
      acc_sgn   = sgn_q;
      acc_rw    = r_width_q;
      acc_ww    = w_width_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // Lane handling: byte offset 0 and half offset 0 are the most significant lanes.
  always_comb begin
    acc_width = acc_wr ? acc_ww : acc_rw;
    is_byte   = (acc_width == 2'b10);
    is_half   = (acc_width == 2'b01);
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_mis   = (is_half & acc_addr[0]) | (~is_byte & ~is_half & (acc_addr[1:0] != 2'b00));
`else
    acc_mis   = 1'b0;
`endif
    idx       = acc_addr[AW+1:2];
    rd_word   = mem[idx];

    wr_word = rd_word;
    if (is_byte)      wr_word[{~acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
    else if (is_half) wr_word[{~acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
    else              wr_word = acc_wdata;

    ld_byte = rd_word[{~acc_addr[1:0], 3'b000} +: 8];
    ld_half = rd_word[{~acc_addr[1], 4'b0000} +: 16];
    if (is_byte)      ld_val = acc_sgn ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
    else if (is_half) ld_val = acc_sgn ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
    else              ld_val = rd_word;
  end

  assign commit = (state != S_RESP) && (next_state == S_RESP);

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == CW'(1)) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register and request capture.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      r_data_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req) begin
        wr_q      <= bus.W_Enable;
        rd_q      <= bus.R_Enable & ~bus.W_Enable;
        sgn_q     <= bus.R_Signed;
        r_width_q <= bus.R_Width;
        w_width_q <= bus.W_Width;
        addr_q    <= bus.Address[AW+1:0];
        wdata_q   <= bus.W_Data;
        cnt       <= CW'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (commit && acc_rd && !acc_mis) r_data_q <= ld_val;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge Clock) begin
    if (!Reset_n)    mis_q <= 1'b0;
    else if (commit) mis_q <= acc_mis;
  end
`endif

  // RAM is not reset; a reset at the commit edge drops the pending write.
  always_ff @(posedge Clock) begin
    if (Reset_n && commit && acc_wr && !acc_mis) mem[idx] <= wr_word;
  end

  // Outputs.
  always_comb begin
    bus.R_Data     = r_data_q;
    bus.Resp_Valid = (state == S_RESP);
    bus.Stall_MEM  = ((state == S_IDLE) && req) || (state == S_WAIT);
`ifdef DMEM_MISALIGN_TRAP_EN
    bus.Misaligned = (state == S_RESP) && mis_q;
`else
    bus.Misaligned = 1'b0;
`endif
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (WAIT_CYCLES=2 and 0) driven with
// directed and random loads/stores; a byte-addressed big-endian model predicts each
// response, which a per-instance monitor compares when Resp_Valid is seen.
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_responder_if if0 ();
  data_memory_responder_if if1 ();

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .bus(if0));
  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .Clock(clk), .Reset_n(rst_n), .bus(if1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_resp [2];
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0]  mdl [2][BYTES];
  logic [31:0] rdata_m [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? if0.Stall_MEM : if1.Stall_MEM;
  endfunction

  function automatic logic get_resp(input int sel);
    return (sel == 0) ? if0.Resp_Valid : if1.Resp_Valid;
  endfunction

  // Reference: memory as a flat byte array, big-endian value order.
  task automatic model(input int sel, input bit rd, input bit wr, input logic [1:0] rw,
                       input logic [1:0] ww, input bit sg, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    logic [1:0]  w;
    int          size, base;
    bit          mis;
    logic [31:0] v;
    w    = wr ? ww : rw;
    size = (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : 4;
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis  = (int'(addr[1:0]) % size) != 0;
`endif
    base = int'(addr % BYTES);
    base = base - (base % size);
    if (!mis) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mdl[sel][base + i] = wdata[8*(size-1-i) +: 8];
      end else if (rd) begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = (v << 8) | {24'h0, mdl[sel][base + i]};
        if (sg && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
        rdata_m[sel] = v;
      end
    end
    e.rdata = rdata_m[sel];
    e.mis   = mis;
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [1:0] rw,
                       input logic [1:0] ww, input bit sg, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (sel == 0) begin
      if0.R_Enable = rd; if0.W_Enable = wr; if0.R_Width = rw; if0.W_Width = ww;
      if0.R_Signed = sg; if0.Address = addr; if0.W_Data = wdata;
    end else begin
      if1.R_Enable = rd; if1.W_Enable = wr; if1.R_Width = rw; if1.W_Width = ww;
      if1.R_Signed = sg; if1.Address = addr; if1.W_Data = wdata;
    end
  endtask

  // chained: issued during the previous response cycle; hold: leave request on the bus.
  task automatic issue(input int sel, input bit rd, input bit wr, input logic [1:0] rw,
                       input logic [1:0] ww, input bit sg, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit chained, input bit hold);
    exp_t e;
    int pre, cnt;
    model(sel, rd, wr, rw, ww, sg, addr, wdata, e);
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    drive(sel, rd, wr, rw, ww, sg, addr, wdata);
    #1;
    pre = 0;
    while (!get_stall(sel) && pre < 3) begin
      @(negedge clk); #1; pre++;
    end
    chk($sformatf("dut%0d stall raised", sel), {31'h0, get_stall(sel)}, 32'h1);
    cnt = 0;
    while (get_stall(sel) && cnt < 20) begin
      cnt++; @(negedge clk); #1;
    end
    chk($sformatf("dut%0d stall cycles", sel), 32'(cnt), 32'(wait_of(sel) + 1));
    chk($sformatf("dut%0d resp after stall", sel), {31'h0, get_resp(sel)}, 32'h1);
    if (chained)
      chk($sformatf("dut%0d back-to-back spacing", sel), 32'(cyc - last_resp[sel]),
          32'(wait_of(sel) + 2));
    last_resp[sel] = cyc;
    if (!hold) begin
      drive(sel, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      @(negedge clk); #1;
    end
  endtask

  task automatic random_run(input int sel, input int n);
    bit chained, hold, rd, wr;
    int op;
    logic [31:0] addr;
    chained = 1'b0;
    for (int k = 0; k < n; k++) begin
      op   = $urandom_range(0, 3);
      rd   = (op != 1);
      wr   = (op == 1) || (op == 2);
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      hold = (k != n - 1) && ($urandom_range(0, 1) == 1);
      issue(sel, rd, wr, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), addr, $urandom, chained, hold);
      chained = hold;
    end
  endtask

  // Scoreboard monitors: one response per Resp_Valid cycle.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (if0.Resp_Valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected response: R_Data 0x%08h with nothing expected", if0.R_Data);
      end else begin
        e = q0.pop_front();
        chk("dut0 R_Data", if0.R_Data, e.rdata);
        chk("dut0 Misaligned", {31'h0, if0.Misaligned}, {31'h0, e.mis});
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.Resp_Valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected response: R_Data 0x%08h with nothing expected", if1.R_Data);
      end else begin
        e = q1.pop_front();
        chk("dut1 R_Data", if1.R_Data, e.rdata);
        chk("dut1 Misaligned", {31'h0, if1.Misaligned}, {31'h0, e.mis});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < BYTES; b++) mdl[s][b] = 8'h00;
      rdata_m[s]   = 32'h0;
      last_resp[s] = 0;
    end
    drive(0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    chk("dut0 reset R_Data", if0.R_Data, 32'h0);
    chk("dut0 reset Stall_MEM", {31'h0, if0.Stall_MEM}, 32'h0);
    chk("dut0 reset Resp_Valid", {31'h0, if0.Resp_Valid}, 32'h0);
    chk("dut0 reset Misaligned", {31'h0, if0.Misaligned}, 32'h0);
    chk("dut1 reset R_Data", if1.R_Data, 32'h0);
    chk("dut1 reset Stall_MEM", {31'h0, if1.Stall_MEM}, 32'h0);

    // Directed lane cases, WAIT_CYCLES=2.
    issue(0, 0, 1, 2'b00, 2'b00, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    issue(0, 1, 0, 2'b00, 2'b00, 0, 32'h10, 32'h0, 0, 0);
    issue(0, 1, 0, 2'b10, 2'b00, 1, 32'h10, 32'h0, 0, 0);
    issue(0, 1, 0, 2'b10, 2'b00, 0, 32'h13, 32'h0, 0, 0);
    issue(0, 0, 1, 2'b00, 2'b01, 0, 32'h12, 32'h0000_1234, 0, 0);
    issue(0, 1, 0, 2'b00, 2'b00, 0, 32'h10, 32'h0, 0, 0);
    issue(0, 0, 1, 2'b00, 2'b10, 0, 32'h11, 32'hFFFF_FF55, 0, 0);
    issue(0, 1, 0, 2'b11, 2'b00, 1, 32'h10, 32'h0, 0, 0);
    random_run(0, 150);

    // Reset while a write sits in WAIT: the write must be dropped.
    drive(0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge clk); #1;
    chk("dut0 stall in WAIT", {31'h0, if0.Stall_MEM}, 32'h1);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    rdata_m[0] = 32'h0;
    rdata_m[1] = 32'h0;
    chk("dut0 R_Data after mid-wait reset", if0.R_Data, 32'h0);
    chk("dut0 stall after mid-wait reset", {31'h0, if0.Stall_MEM}, 32'h0);
    @(negedge clk); #1;
    issue(0, 1, 0, 2'b00, 2'b00, 0, 32'h20, 32'h0, 0, 0);
    issue(0, 1, 0, 2'b00, 2'b00, 0, 32'h22, 32'h0, 0, 0);
    issue(0, 1, 0, 2'b01, 2'b00, 1, 32'h21, 32'h0, 0, 0);

    // WAIT_CYCLES=0: back-to-back requests and read+write collision.
    issue(1, 0, 1, 2'b00, 2'b00, 0, 32'h40, 32'h11223344, 0, 1);
    issue(1, 1, 0, 2'b00, 2'b00, 0, 32'h40, 32'h0, 1, 1);
    issue(1, 1, 0, 2'b10, 2'b00, 0, 32'h41, 32'h0, 1, 1);
    issue(1, 1, 1, 2'b00, 2'b00, 0, 32'h44, 32'hAABBCCDD, 1, 1);
    issue(1, 1, 0, 2'b00, 2'b00, 0, 32'h44, 32'h0, 1, 0);
    random_run(1, 150);

    repeat (4) @(negedge clk);
    chk("dut0 scoreboard drained", 32'(q0.size()), 32'h0);
    chk("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
